clock_divider_multi: RTL and testbench
======================================

# clock_divider_multi

Parametrised multi-channel successor to the single fixed 100 MHz → 10 kHz divider. It generates NUM_CH independent divided clocks from clk_100mHz_in, each with a runtime-programmable divisor. Each channel also produces a one-cycle tick strobe on every output edge. Divisor changes apply glitch-free at the channel's next terminal count, and a global sync input phase-aligns all channels. It feeds the seven-segment display multiplexer and other slow-rate logic that previously needed separate fixed dividers.

## Interface
Parameters:
- NUM_CH, 4, number of independent divider channels (≥1).
- CNT_W, 16, counter and divisor width in bits.
- DEFAULT_DIV, 5000, half-period divisor loaded at reset; 5000 gives 10 kHz from 100 MHz.

Ports:
- clk_100mHz_in  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- enable  in  NUM_CH  per-channel run enable, level-sensitive.
- sync  in  1  one-cycle pulse; restarts all channels in phase.
- cfg_we  in  1  divisor write strobe.
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel of the write.
- cfg_div  in  CNT_W  new half-period divisor D; valid range 1..2^CNT_W-1.
- clk_out  out  NUM_CH  divided clocks, period 2·D cycles, 50% duty.
- tick  out  NUM_CH  one-cycle strobe coincident with every clk_out transition.
- pend  out  NUM_CH  a divisor write is waiting for the channel's terminal count.
- cfg_err  out  1  one-cycle pulse when a write is rejected.

## Operation
- Per-channel state: cnt[CNT_W], div[CNT_W], pdiv[CNT_W], pend, clk_out, tick. All outputs are registered.
- Reset values: cnt=0, div=DEFAULT_DIV, pdiv=0, pend=0, clk_out=0, tick=0, cfg_err=0.
- States per channel:
  - IDLE (enable=0): cnt is held at 0 and clk_out is forced to 0. tick=0.
  - RUN (enable=1): counting.
  - IDLE→RUN starts counting from 0.
  - RUN→IDLE clears cnt and drives clk_out low on the next edge. No partial pulse is extended.
- RUN, terminal count (cnt == div-1):
  - cnt←0, clk_out toggles, tick←1 for one cycle.
  - If pend=1: div←pdiv and pend←0 on that same edge. The new divisor governs the following half-period.
- RUN, otherwise: cnt←cnt+1 and tick←0.
- D=1: clk_out toggles every cycle (clk/2) and tick is held high.
- Divisor write (cfg_we=1, cfg_ch<NUM_CH, cfg_div≠0):
  - Channel in RUN: pdiv←cfg_div and pend←1. A second write before terminal count overwrites pdiv; last write wins.
  - Channel in IDLE: div←cfg_div immediately and pend stays 0.
- Rejected write (cfg_div==0 or cfg_ch≥NUM_CH): no state change, cfg_err←1 for one cycle.
- sync=1, applied to every enabled channel:
  - cnt←0, clk_out←0, tick←0.
  - Any pending pdiv is applied immediately and pend←0.
  - Disabled channels are unaffected.
- sync and a valid cfg_we in the same cycle: sync takes effect, then the write goes directly to div for the target channel (pend stays 0).
- A write in the same cycle as that channel's terminal count: the old pdiv (if any) is applied at this edge. The new value becomes pdiv with pend=1.
- Asynchronous reset mid-operation returns all state to reset values immediately. Counting resumes on the first clock after release where enable=1.

## Timing
- Latency from enable rising (sampled at edge E0) to the first clk_out rise: D edges, i.e. clk_out goes high at edge E0+D. Likewise sync sampled at edge S0 puts clk_out low at S0, and its first rise is at S0+D.
- tick is high during exactly the cycle following each clk_out transition edge.
- Divisor write latency:
  - pend rises one edge after cfg_we.
  - div updates at the first terminal count after that.
  - The new period is visible within at most old D + new D cycles.
- cfg_err is asserted one edge after the offending cfg_we.
- No combinational path from any input to any output.

## Test plan
- Reset release, enable=4'b0001, defaults → clk_out[0] has period 10000 cycles with high time 5000. tick[0] pulses every 5000 cycles. Other channels stay 0.
- Write ch1 D=3 while running at D=5 → pend[1]=1 until the next terminal count. The half-period is 5 then 3 thereafter, with no short or glitched pulse.
- Write D=0, then write cfg_ch=NUM_CH → cfg_err pulses once for each write. div and pend are unchanged.
- Channels 0..3 at D=2,3,4,5, all enabled, then sync pulse → all clk_out go low together. The first rises are at 2,3,4,5 edges after sync.
- D=1 on ch2 → clk_out[2] toggles every cycle and tick[2] stays high. Dropping enable gives clk_out[2]=0 and tick[2]=0 on the next edge.
- Assert reset mid-count with pend set → all outputs are 0 immediately, div=5000, pend=0. After release the first clk_out rise is at 5000 edges.

Source files
------------

// File: rtl/clock_divider_multi.sv
// clock_divider_multi: NUM_CH independent programmable clock dividers.
// Divisor changes land at terminal count; sync restarts all in phase.
module clock_divider_multi #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 16,
   parameter int DEFAULT_DIV = 5000,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_100mHz_in,
   input  logic              reset,
   input  logic [NUM_CH-1:0] enable,
   input  logic              sync,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] pend,
   output logic              cfg_err
);

   logic ch_ok;
   logic div_ok;
   logic cfg_ok;

   // A write is accepted only for an existing channel and a nonzero divisor
   always_comb begin
      ch_ok  = int'(cfg_ch) < NUM_CH;
      div_ok = cfg_div != '0;
      cfg_ok = cfg_we && ch_ok && div_ok;
   end

   // Rejected writes raise a one-cycle error pulse
   always_ff @(posedge clk_100mHz_in or posedge reset) begin
      if (reset) begin
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= cfg_we && !(ch_ok && div_ok);
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] div;
      logic [CNT_W-1:0] pdiv;
      logic             run_q;
      logic             clk_q;
      logic             tick_q;
      logic             pend_q;
      logic             wr_hit;
      logic             term;

      // Decode a valid write to this channel and its terminal count
      always_comb begin
         wr_hit = cfg_ok && (cfg_ch == CH_W'(i));
         term   = cnt == (div - CNT_W'(1));
      end

      // Channel state: idle hold, restart, terminal toggle, or count
      always_ff @(posedge clk_100mHz_in or posedge reset) begin
         if (reset) begin
            cnt    <= '0;
            div    <= CNT_W'(DEFAULT_DIV);
            pdiv   <= '0;
            run_q  <= 1'b0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
            pend_q <= 1'b0;
         end else if (!enable[i]) begin
            run_q  <= 1'b0;
            cnt    <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
            if (wr_hit) begin
               div    <= cfg_div;
               pend_q <= 1'b0;
            end
         end else if (!run_q || sync) begin
            run_q  <= 1'b1;
            cnt    <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
            if (wr_hit) begin
               div    <= cfg_div;
               pend_q <= 1'b0;
            end else if (pend_q) begin
               div    <= pdiv;
               pend_q <= 1'b0;
            end
         end else if (term) begin
            cnt    <= '0;
            clk_q  <= !clk_q;
            tick_q <= 1'b1;
            if (pend_q) begin
               div <= pdiv;
            end
            pend_q <= wr_hit;
            if (wr_hit) begin
               pdiv <= cfg_div;
            end
         end else begin
            cnt    <= cnt + CNT_W'(1);
            tick_q <= 1'b0;
            if (wr_hit) begin
               pdiv   <= cfg_div;
               pend_q <= 1'b1;
            end
         end
      end

      assign clk_out[i] = clk_q;
      assign tick[i]    = tick_q;
      assign pend[i]    = pend_q;
   end

endmodule

// File: tb/tb_clock_divider_multi.sv
// tb_clock_divider_multi: directed + random checks of clock_divider_multi
// against a half-period countdown reference model.
module tb_clock_divider_multi;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 16;
   localparam int DDIV   = 5000;

   logic              clk_100mHz_in = 1'b0;
   logic              reset = 1'b1;
   logic [NUM_CH-1:0] enable = '0;
   logic              sync = 1'b0;
   logic              cfg_we = 1'b0;
   logic [1:0]        cfg_ch = '0;
   logic [CNT_W-1:0]  cfg_div = '0;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] pend;
   logic              cfg_err;

   logic [2:0] enable3 = '0;
   logic       sync3 = 1'b0;
   logic       cfg_we3 = 1'b0;
   logic [1:0] cfg_ch3 = '0;
   logic [7:0] cfg_div3 = '0;
   logic [2:0] clk_out3;
   logic [2:0] tick3;
   logic [2:0] pend3;
   logic       cfg_err3;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   bit chk_on = 0;

   clock_divider_multi #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DDIV)
   ) u_dut (
      .clk_100mHz_in(clk_100mHz_in), .reset(reset), .enable(enable),
      .sync(sync), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
      .clk_out(clk_out), .tick(tick), .pend(pend), .cfg_err(cfg_err)
   );

   clock_divider_multi #(
      .NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(4)
   ) u_dut3 (
      .clk_100mHz_in(clk_100mHz_in), .reset(reset), .enable(enable3),
      .sync(sync3), .cfg_we(cfg_we3), .cfg_ch(cfg_ch3), .cfg_div(cfg_div3),
      .clk_out(clk_out3), .tick(tick3), .pend(pend3), .cfg_err(cfg_err3)
   );

   always #5 clk_100mHz_in = !clk_100mHz_in;

   always @(posedge clk_100mHz_in) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: cycles left in the current half-period
   int m_left [NUM_CH];
   int m_div  [NUM_CH];
   int m_pdiv [NUM_CH];
   bit m_run  [NUM_CH];
   bit m_clk  [NUM_CH];
   bit m_tick [NUM_CH];
   bit m_pend [NUM_CH];
   bit m_err;

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_left[i] = 0;
         m_div[i]  = DDIV;
         m_pdiv[i] = 0;
         m_run[i]  = 0;
         m_clk[i]  = 0;
         m_tick[i] = 0;
         m_pend[i] = 0;
      end
      m_err = 0;
   endtask

   task automatic model_step();
      bit wr;
      for (int i = 0; i < NUM_CH; i++) begin
         wr = cfg_we && cfg_div != 0 && int'(cfg_ch) == i;
         if (!enable[i]) begin
            m_run[i] = 0;
            m_clk[i] = 0;
            m_tick[i] = 0;
            if (wr) begin
               m_div[i] = int'(cfg_div);
               m_pend[i] = 0;
            end
         end else if (!m_run[i] || sync) begin
            m_run[i] = 1;
            m_clk[i] = 0;
            m_tick[i] = 0;
            if (wr) begin
               m_div[i] = int'(cfg_div);
               m_pend[i] = 0;
            end else if (m_pend[i]) begin
               m_div[i] = m_pdiv[i];
               m_pend[i] = 0;
            end
            m_left[i] = m_div[i];
         end else begin
            m_left[i]--;
            if (m_left[i] == 0) begin
               m_clk[i] = !m_clk[i];
               m_tick[i] = 1;
               if (m_pend[i]) m_div[i] = m_pdiv[i];
               m_left[i] = m_div[i];
               m_pend[i] = wr;
               if (wr) m_pdiv[i] = int'(cfg_div);
            end else begin
               m_tick[i] = 0;
               if (wr) begin
                  m_pdiv[i] = int'(cfg_div);
                  m_pend[i] = 1;
               end
            end
         end
      end
      m_err = cfg_we && (cfg_div == 0 || int'(cfg_ch) >= NUM_CH);
   endtask

   initial model_reset();

   always @(posedge clk_100mHz_in or posedge reset) begin
      if (reset) model_reset();
      else model_step();
   end

   // Every-cycle comparison against the model
   always @(negedge clk_100mHz_in) begin
      if (chk_on) begin
         for (int i = 0; i < NUM_CH; i++) begin
            chk($sformatf("clk_out[%0d]", i), 32'(clk_out[i]), 32'(m_clk[i]));
            chk($sformatf("tick[%0d]", i), 32'(tick[i]), 32'(m_tick[i]));
            chk($sformatf("pend[%0d]", i), 32'(pend[i]), 32'(m_pend[i]));
         end
         chk("cfg_err", 32'(cfg_err), 32'(m_err));
      end
   end

   task automatic wr_cfg(input int ch, input int d);
      cfg_we = 1'b1;
      cfg_ch = 2'(ch);
      cfg_div = CNT_W'(d);
      @(negedge clk_100mHz_in);
      cfg_we = 1'b0;
   endtask

   task automatic wait_edge(input int ch, input bit level, input int lim,
                            output int c);
      bit prev;
      bit seen;
      prev = clk_out[ch];
      seen = 0;
      c = -1;
      for (int k = 0; k < lim && !seen; k++) begin
         @(negedge clk_100mHz_in);
         if (clk_out[ch] == level && prev != level) begin
            seen = 1;
            c = cyc;
         end
         prev = clk_out[ch];
      end
      if (!seen) chk("edge_timeout", 0, 1);
   endtask

   initial begin
      int r, c0, c1, c2;
      int first [NUM_CH];
      bit a;
      enable = 4'b0001;
      repeat (3) @(negedge clk_100mHz_in);
      chk_on = 1;
      chk("rst_clk_out", 32'(clk_out), 0);
      chk("rst_tick", 32'(tick), 0);
      chk("rst_pend", 32'(pend), 0);
      chk("rst_cfg_err", 32'(cfg_err), 0);

      reset = 1'b0;
      r = cyc;
      wait_edge(0, 1'b1, 6000, c0);
      chk("first_rise", 32'(c0 - (r + 1)), DDIV);
      wait_edge(0, 1'b0, 6000, c1);
      chk("high_time", 32'(c1 - c0), DDIV);
      wait_edge(0, 1'b1, 6000, c2);
      chk("period", 32'(c2 - c0), 2 * DDIV);
      chk("other_ch_low", 32'(clk_out[3:1]), 0);

      wr_cfg(0, 0);
      chk("err_div0", 32'(cfg_err), 1);
      chk("err_div0_pend", 32'(pend), 0);
      @(negedge clk_100mHz_in);
      chk("err_one_cycle", 32'(cfg_err), 0);
      cfg_we3 = 1'b1;
      cfg_ch3 = 2'd3;
      cfg_div3 = 8'd5;
      @(negedge clk_100mHz_in);
      cfg_we3 = 1'b0;
      chk("err_bad_ch", 32'(cfg_err3), 1);
      chk("err_bad_ch_pend", 32'(pend3), 0);
      @(negedge clk_100mHz_in);
      chk("err_bad_ch_once", 32'(cfg_err3), 0);

      enable = '0;
      @(negedge clk_100mHz_in);
      wr_cfg(0, 2);
      wr_cfg(1, 5);
      wr_cfg(2, 4);
      wr_cfg(3, 5);
      chk("idle_wr_pend", 32'(pend), 0);
      enable = 4'b1111;
      repeat (12) @(negedge clk_100mHz_in);
      wr_cfg(1, 3);
      chk("run_wr_pend", 32'(pend[1]), 1);
      for (int k = 0; k < 12 && pend[1]; k++) @(negedge clk_100mHz_in);
      chk("pend_cleared", 32'(pend[1]), 0);
      repeat (7) @(negedge clk_100mHz_in);

      sync = 1'b1;
      r = cyc;
      @(negedge clk_100mHz_in);
      sync = 1'b0;
      chk("sync_low", 32'(clk_out), 0);
      for (int i = 0; i < NUM_CH; i++) first[i] = -1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk_100mHz_in);
         for (int i = 0; i < NUM_CH; i++)
            if (clk_out[i] && first[i] < 0) first[i] = cyc - (r + 1);
      end
      for (int i = 0; i < NUM_CH; i++)
         chk($sformatf("sync_rise[%0d]", i), 32'(first[i]), 32'(i + 2));

      wr_cfg(2, 1);
      repeat (10) @(negedge clk_100mHz_in);
      for (int k = 0; k < 3; k++) begin
         a = clk_out[2];
         @(negedge clk_100mHz_in);
         chk("d1_toggle", 32'(clk_out[2]), 32'(!a));
         chk("d1_tick", 32'(tick[2]), 1);
      end
      enable[2] = 1'b0;
      @(negedge clk_100mHz_in);
      chk("stop_clk", 32'(clk_out[2]), 0);
      chk("stop_tick", 32'(tick[2]), 0);

      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 63) == 0)
            enable[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
         cfg_we = $urandom_range(0, 7) == 0;
         cfg_ch = 2'($urandom_range(0, NUM_CH - 1));
         cfg_div = CNT_W'($urandom_range(0, 8));
         sync = $urandom_range(0, 39) == 0;
         @(negedge clk_100mHz_in);
      end
      cfg_we = 1'b0;
      sync = 1'b0;

      enable = 4'b0001;
      repeat (3) @(negedge clk_100mHz_in);
      wr_cfg(0, 7);
      chk("pre_rst_pend", 32'(pend[0]), 1);
      #3 reset = 1'b1;
      #1;
      chk("mid_rst_clk", 32'(clk_out), 0);
      chk("mid_rst_tick", 32'(tick), 0);
      chk("mid_rst_pend", 32'(pend), 0);
      chk("mid_rst_err", 32'(cfg_err), 0);
      @(negedge clk_100mHz_in);
      reset = 1'b0;
      r = cyc;
      wait_edge(0, 1'b1, 6000, c0);
      chk("rst_first_rise", 32'(c0 - (r + 1)), DDIV);

      chk_on = 0;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
